pwm_channel_array: RTL and testbench
====================================

// Module: pwm_channel_array
// PURPOSE
//  Parametrised multi-channel PWM generator for the photonic switch drivers; next generation of the fixed two-channel A/B PWM path.
//  Integrated prescaler derives a tick enable from the core clock, so no external 1 MHz enable is needed.
//  A shared phase counter drives N_CH comparators. Per-channel duties are written through a valid/ready port
//  into shadow registers and applied glitch-free at frame boundaries.
// PARAMETERS
//  N_CH   2  number of PWM channels
//  CH_W   1  width of channel index (2**CH_W >= N_CH)
//  CNT_W  7  width of phase counter, period and duty values
//  DIV_W  5  width of prescaler divide value
// PORTS
//  clk       in   1       core clock
//  reset     in   1       asynchronous, active-high reset
//  en        in   1       global enable; low = idle, counters cleared
//  div       in   DIV_W   tick every div+1 clk cycles; sampled at frame boundary / while idle
//  period    in   CNT_W   frame length = period+1 ticks; sampled at frame boundary / while idle
//  wr_valid  in   1       duty write request
//  wr_ch     in   CH_W    channel index of write
//  wr_duty   in   CNT_W   duty in ticks (high while phase < duty)
//  wr_ready  out  1       write accepted when wr_valid && wr_ready
//  wr_err    out  1       1-cycle pulse: accepted write had wr_ch >= N_CH
//  tick      out  1       prescaler tick (combinational, 1 clk wide)
//  frame_start out 1      1-cycle pulse in first cycle of each frame (phase==0)
//  pwm_out   out  N_CH    registered PWM outputs
// BEHAVIOUR
//  Reset (async, active-high): pre_cnt, phase, div_act, period_act, all duty_sh/duty_act = 0;
//   pwm_out=0, wr_err=0, frame_start=0. Reset applies immediately, also mid-frame.
//  Prescaler: tick = en && (pre_cnt == div_act). If !en: pre_cnt<=0.
//   Else if tick: pre_cnt<=0. Else pre_cnt<=pre_cnt+1. div=0 -> tick every clk.
//  Phase: frame_end = tick && (phase == period_act). If !en: phase<=0.
//   Else on tick: phase <= frame_end ? 0 : phase+1.
//  Active registers: while !en, div_act<=div, period_act<=period, duty_act[i]<=duty_sh[i] every clk.
//   On frame_end all three load the same way, on the same edge that phase wraps to 0.
//   Otherwise they hold.
//  Output: pwm_out[i] <= en && (phase < duty_act[i]); one clk latency from phase.
//   duty=0 -> constant low. duty >= period+1 -> constant high (no wrap glitch).
//   en low -> pwm_out=0 on next edge.
//  Write port: wr_ready = !frame_end (combinational). A write colliding with a frame boundary stalls one clk.
//   Accepted write with wr_ch < N_CH: duty_sh[wr_ch] <= wr_duty.
//   Visible at pwm_out starting from the next frame boundary. Never mid-frame.
//   Accepted write with wr_ch >= N_CH: no state change, wr_err=1 for the following cycle.
//   Back-to-back writes are allowed; the last write per channel before frame_end wins.
//  frame_start <= en && (frame_end || !en_d), where en_d is en delayed one clk.
//   It pulses in the first frame cycle, including after enable rises.
//  Arithmetic: all counters unsigned, compare unsigned, no saturation needed.
//   Phase never exceeds period_act because period_act changes only at wrap.
// TESTING
//  1 N_CH=2, div=1, period=9, duty0=3, duty1=10, en=1 -> tick every 2 clk; frame 20 clk;
//    pwm_out[0] high 6 clk/20; pwm_out[1] constant high.
//  2 Mid-frame write ch0 duty=5 -> pwm_out[0] keeps 6-clk pulse this frame; 10-clk pulses from next frame_start.
//  3 wr_valid asserted in frame_end cycle -> wr_ready=0 that cycle; accepted next clk.
//    Value appears one frame later than an earlier write would.
//  4 duty0=0 -> pwm_out[0] constant 0. Write wr_ch=3 (CH_W=2, N_CH=2) -> wr_err 1-clk pulse; duties unchanged.
//  5 Drop en at phase 4 -> pwm_out=0 next edge, phase/pre_cnt=0. Change period=4, re-raise en ->
//    frame_start pulses; first frame is 5 ticks with new period.
//  6 Assert reset mid-frame with pwm_out high -> pwm_out=0 without clk edge; all duties 0 after release.

Source files
------------

// File: rtl/pwm_channel_array_if.sv
// Duty write port: valid/ready handshake carrying channel index and duty,
// plus a one-cycle error flag for writes to a non-existent channel.
interface pwm_channel_array_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 7
);
    logic             wr_valid;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_duty;
    logic             wr_ready;
    logic             wr_err;

    modport master (
        output wr_valid, wr_ch, wr_duty,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_ch, wr_duty,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/pwm_channel_array.sv
// Multi-channel PWM: prescaler tick, shared phase counter, per-channel
// shadow duties that take effect only at frame boundaries.
module pwm_channel_array #(
    parameter int N_CH  = 2,
    parameter int CH_W  = 1,
    parameter int CNT_W = 7,
    parameter int DIV_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DIV_W-1:0]   div,
    input  logic [CNT_W-1:0]   period,
    pwm_channel_array_if.slave wr,
    output logic               tick,
    output logic               frame_start,
    output logic [N_CH-1:0]    pwm_out
);

    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_act;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_sh  [N_CH];
    logic [CNT_W-1:0] duty_act [N_CH];
    logic             en_d;
    logic             frame_end;
    logic             load;
    logic             accept;
    logic             ch_ok;

    assign tick        = en && (pre_cnt == div_act);
    assign frame_end   = tick && (phase == period_act);
    assign load        = !en || frame_end;
    assign wr.wr_ready = !frame_end;
    assign accept      = wr.wr_valid && !frame_end;
    assign ch_ok       = {1'b0, wr.wr_ch} < (CH_W+1)'(N_CH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt     <= '0;
            phase       <= '0;
            div_act     <= '0;
            period_act  <= '0;
            en_d        <= 1'b0;
            frame_start <= 1'b0;
            wr.wr_err   <= 1'b0;
        end else begin
            en_d        <= en;
            frame_start <= en && (frame_end || !en_d);
            wr.wr_err   <= accept && !ch_ok;
            if (!en) begin
                pre_cnt <= '0;
                phase   <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                phase   <= frame_end ? '0 : phase + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            // Period and divider only move at wrap, so phase stays in range
            if (load) begin
                div_act    <= div;
                period_act <= period;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (accept && ch_ok && (wr.wr_ch == CH_W'(i)))
                    duty_sh[i] <= wr.wr_duty;
                if (load)
                    duty_act[i] <= duty_sh[i];
                pwm_out[i] <= en && (phase < duty_act[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_channel_array.sv
// Bench for pwm_channel_array: table of duty/period cases, directed
// corner sequences and random traffic against a frame-time model.
module tb_pwm_channel_array;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [4:0] div = '0;
    logic [6:0] period = '0;
    logic       tick;
    logic       frame_start;
    logic [1:0] pwm_out;

    int checks = 0;
    int failures = 0;

    pwm_channel_array_if #(.CH_W(2), .CNT_W(7)) wif();

    pwm_channel_array #(
        .N_CH(2), .CH_W(2), .CNT_W(7), .DIV_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .div(div),
        .period(period),
        .wr(wif),
        .tick(tick),
        .frame_start(frame_start),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Model: one counter of clocks elapsed in the frame; phase and tick
    // follow from it by division, frame length is (div+1)*(period+1).
    int m_c, m_div, m_per;
    int m_sh[2];
    int m_act[2];
    bit m_pwm[2];
    bit m_fs, m_err, m_en_d, m_tick, m_fe;

    function automatic void m_reset();
        m_c = 0; m_div = 0; m_per = 0;
        m_fs = 0; m_err = 0; m_en_d = 0;
        for (int i = 0; i < 2; i++) begin
            m_sh[i] = 0; m_act[i] = 0; m_pwm[i] = 0;
        end
    endfunction

    function automatic void m_comb();
        m_tick = en && ((m_c % (m_div + 1)) == m_div);
        m_fe   = en && (m_c == (m_div + 1) * (m_per + 1) - 1);
    endfunction

    function automatic void m_step();
        bit acc;
        int ph;
        m_comb();
        acc = wif.wr_valid && !m_fe;
        ph  = m_c / (m_div + 1);
        for (int i = 0; i < 2; i++)
            m_pwm[i] = en && (ph < m_act[i]);
        m_fs  = en && (m_fe || !m_en_d);
        m_err = acc && (int'(wif.wr_ch) >= 2);
        if (!en || m_fe) begin
            m_act[0] = m_sh[0];
            m_act[1] = m_sh[1];
            m_div = int'(div);
            m_per = int'(period);
        end
        if (acc && int'(wif.wr_ch) < 2)
            m_sh[int'(wif.wr_ch)] = int'(wif.wr_duty);
        m_c = (!en || m_fe) ? 0 : m_c + 1;
        m_en_d = en;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", n, $time, act, exp);
        end
    endtask

    task automatic cyc();
        #1;
        m_comb();
        chk("tick", 32'(tick), 32'(m_tick));
        chk("wr_ready", 32'(wif.wr_ready), 32'(!m_fe));
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), {30'd0, m_pwm[1], m_pwm[0]});
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("wr_err", 32'(wif.wr_err), 32'(m_err));
    endtask

    task automatic wr(input int ch, input int duty);
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 2'(ch);
        wif.wr_duty  = 7'(duty);
        cyc();
        wif.wr_valid = 1'b0;
    endtask

    task automatic wait_fs(input int nfs, input int limit);
        int seen = 0;
        int n = 0;
        while (seen < nfs && n < limit) begin
            cyc();
            if (frame_start) seen++;
            n++;
        end
        if (seen < nfs) chk("fs_timeout", 32'(seen), 32'(nfs));
    endtask

    task automatic count_win(input int len, output int h0, output int h1);
        h0 = int'(pwm_out[0]);
        h1 = int'(pwm_out[1]);
        repeat (len - 1) begin
            cyc();
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end
    endtask

    typedef struct {
        int dv; int per; int d0; int d1; int h0; int h1;
    } vec_t;

    vec_t vt[5];

    initial begin
        int h0, h1, n;
        vt[0] = '{1, 9, 3, 10, 6, 20};
        vt[1] = '{0, 4, 0, 2, 0, 2};
        vt[2] = '{2, 3, 1, 4, 3, 12};
        vt[3] = '{0, 7, 7, 8, 7, 8};
        vt[4] = '{3, 2, 2, 0, 8, 0};

        wif.wr_valid = 1'b0;
        wif.wr_ch    = '0;
        wif.wr_duty  = '0;
        m_reset();
        @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_err", 32'(wif.wr_err), 0);
        reset = 1'b0;
        cyc();

        // Steady-state high time per frame for each configuration
        for (int v = 0; v < 5; v++) begin
            int len;
            len = (vt[v].dv + 1) * (vt[v].per + 1);
            en = 1'b0;
            div = 5'(vt[v].dv);
            period = 7'(vt[v].per);
            wr(0, vt[v].d0);
            wr(1, vt[v].d1);
            cyc();
            en = 1'b1;
            wait_fs(2, 3 * len + 10);
            count_win(len, h0, h1);
            chk($sformatf("vec%0d_h0", v), 32'(h0), 32'(vt[v].h0));
            chk($sformatf("vec%0d_h1", v), 32'(h1), 32'(vt[v].h1));
        end

        // Mid-frame write only lands at the next boundary
        en = 1'b0; div = 5'd1; period = 7'd9;
        wr(0, 3); wr(1, 10);
        en = 1'b1;
        wait_fs(2, 60);
        n = 0;
        while (m_c != 10 && n < 40) begin cyc(); n++; end
        wr(0, 5);
        wait_fs(1, 40);
        count_win(20, h0, h1);
        chk("midwr_h0", 32'(h0), 10);

        // Write colliding with frame_end stalls, lands one frame later
        n = 0;
        m_comb();
        while (!m_fe && n < 50) begin cyc(); m_comb(); n++; end
        wif.wr_valid = 1'b1; wif.wr_ch = 2'd0; wif.wr_duty = 7'd2;
        #1;
        chk("collide_ready", 32'(wif.wr_ready), 0);
        cyc();
        h0 = int'(pwm_out[0]);
        cyc();
        wif.wr_valid = 1'b0;
        h0 += int'(pwm_out[0]);
        repeat (18) begin cyc(); h0 += int'(pwm_out[0]); end
        chk("collide_frame_h0", 32'(h0), 10);
        wait_fs(1, 40);
        count_win(20, h0, h1);
        chk("late_h0", 32'(h0), 4);

        // Bad channel index: error pulse, duties untouched
        en = 1'b0;
        cyc();
        wr(3, 50);
        chk("err_pulse", 32'(wif.wr_err), 1);
        cyc();
        chk("err_clear", 32'(wif.wr_err), 0);
        chk("err_sh0", 32'(m_sh[0]), 2);
        wr(0, 3);
        en = 1'b1;
        wait_fs(2, 60);
        count_win(20, h0, h1);
        chk("after_err_h0", 32'(h0), 6);
        chk("after_err_h1", 32'(h1), 20);

        // Drop enable at phase 4, shorten period, re-enable
        n = 0;
        while ((m_c / (m_div + 1)) != 4 && n < 40) begin cyc(); n++; end
        en = 1'b0;
        cyc();
        chk("en_drop_pwm", 32'(pwm_out), 0);
        period = 7'd4;
        cyc();
        en = 1'b1;
        cyc();
        chk("reen_fs", 32'(frame_start), 1);
        count_win(10, h0, h1);
        chk("reen_h0", 32'(h0), 6);
        chk("reen_h1", 32'(h1), 10);
        chk("reen_fs2", 32'(frame_start), 1);

        // Asynchronous reset mid-frame with pwm high
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 0);
        chk("async_rst_fs", 32'(frame_start), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_fs(2, 60);
        count_win(10, h0, h1);
        chk("post_rst_h0", 32'(h0), 0);
        chk("post_rst_h1", 32'(h1), 0);

        // Random traffic against the model
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            if ($urandom_range(0, 59) == 0) begin
                div = 5'($urandom_range(0, 3));
                period = 7'($urandom_range(0, 15));
            end
            wif.wr_valid = ($urandom_range(0, 9) < 3);
            wif.wr_ch    = 2'($urandom_range(0, 3));
            wif.wr_duty  = 7'($urandom_range(0, 17));
            cyc();
        end
        wif.wr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
